// File: rtl/nod_div_pkg.sv
// -----------------------------------------------------------------------------
// nod_div_pkg
// Shared widths, constants and types for the logarithmic approximate divider.
//   OP_W   : operand width (unsigned dividend / divisor)
//   K_W    : width of the rounded characteristic k (0..8)
//   F_W    : width of the signed Q.8 fraction f (-64..127)
//   L_W    : width of the signed Q5.8 log difference
//   Q_W    : width of the Q8.8 quotient
//   Q_SAT  : saturated quotient (also the divide-by-zero result)
// Helper: lead_one_pos() returns the index of the most significant set bit.
// -----------------------------------------------------------------------------
package nod_div_pkg;

    localparam int OP_W  = 8;
    localparam int K_W   = 4;
    localparam int F_W   = 9;
    localparam int L_W   = 14;
    localparam int Q_W   = 16;
    localparam int POS_W = 3;

    localparam logic [Q_W-1:0] Q_SAT = 16'hFFFF;

    // One encoded operand as it travels through the first pipeline stage.
    typedef struct packed {
        logic                  zero;
        logic [K_W-1:0]        k;
        logic signed [F_W-1:0] f;
    } enc_t;

    localparam enc_t ENC_CLR = '{zero: 1'b0, k: 4'd0, f: 9'sd0};

    // Index of the most significant set bit; 0 for an all-zero input
    // (callers qualify that case with their own zero detect).
    function automatic logic [POS_W-1:0] lead_one_pos(input logic [OP_W-1:0] v);
        logic [POS_W-1:0] pos;
        pos = 3'd0;
        for (int i = 0; i < OP_W; i++) begin
            if (v[i]) begin
                pos = POS_W'(i);
            end else begin
                pos = pos;
            end
        end
        return pos;
    endfunction

endpackage : nod_div_pkg

// File: rtl/nod_log_encode.sv
// -----------------------------------------------------------------------------
// nod_log_encode
// Combinational log encoder for one unsigned operand.
// The operand is approximated as 2^k + r, where k is the leading-one position
// rounded to the nearer power of two (ties go up), and r is the signed
// residual. The residual is rescaled to a Q.8 fraction f = r << (8 - k) so
// that log2(v) ~= k + f/256.
// Ports:
//   v    : unsigned operand
//   k    : rounded characteristic, 0..8
//   f    : signed Q.8 fraction, -64..127
//   zero : operand is zero (k and f forced to 0)
// -----------------------------------------------------------------------------
module nod_log_encode
    import nod_div_pkg::*;
(
    input  logic [OP_W-1:0]       v,
    output logic [K_W-1:0]        k,
    output logic signed [F_W-1:0] f,
    output logic                  zero
);

    logic [POS_W-1:0] p_s;
    logic             half_s;
    logic [K_W-1:0]   k_s;
    logic [F_W-1:0]   r_s;
    logic [K_W-1:0]   sh_s;

    // Characteristic: leading-one position, bumped up when the next bit down is set
    always_comb begin
        p_s = lead_one_pos(v);
        if (p_s != 3'd0) begin
            half_s = v[p_s - 3'd1];
        end else begin
            half_s = 1'b0;
        end
        k_s = {1'b0, p_s} + {3'b000, half_s};
    end

    // Residual and fraction. Both fit in F_W signed bits, so modular
    // F_W-bit arithmetic yields the exact value without wider intermediates.
    always_comb begin
        r_s  = {1'b0, v} - (9'd1 << k_s);
        sh_s = 4'd8 - k_s;
        if (v == 8'd0) begin
            zero = 1'b1;
            k    = 4'd0;
            f    = 9'sd0;
        end else begin
            zero = 1'b0;
            k    = k_s;
            f    = $signed(r_s << sh_s);
        end
    end

endmodule : nod_log_encode

// File: rtl/nod_log_divider.sv
// -----------------------------------------------------------------------------
// nod_log_divider
// Three-stage logarithmic approximate divider, q ~= x / y in unsigned Q8.8.
//   S1 : encode x and y into (k, f) log form
//   S2 : log difference L = ((kx - ky) << 8) + fx - fy   (signed Q5.8)
//   S3 : antilog q = (256 + L[7:0]) shifted by n = L >>> 8, saturating
// The pipeline advances as one unit whenever the output register is empty or
// being consumed; a stalled output freezes every stage.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   valid_i : operand pair valid        ready_o : operand pair accepted
//   x_i     : unsigned dividend         y_i     : unsigned divisor
//   valid_o : result valid              ready_i : result consumed
//   q_o     : Q8.8 quotient             dz_o    : divide by zero
// -----------------------------------------------------------------------------
module nod_log_divider
    import nod_div_pkg::*;
#(
    parameter int FRAC_W = 8
)(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [OP_W-1:0] x_i,
    input  logic [OP_W-1:0] y_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [Q_W-1:0]  q_o,
    output logic            dz_o
);

    // Width of the integer part n of L, and of the mantissa 1.m
    localparam int N_W = L_W - FRAC_W;
    localparam int M_W = FRAC_W + 1;
    // Any shift of n or more overflows the quotient
    localparam logic [N_W-1:0] N_SAT = N_W'(Q_W - FRAC_W);

    logic                  advance_s;
    logic                  accept_s;

    logic [K_W-1:0]        kx_s;
    logic [K_W-1:0]        ky_s;
    logic signed [F_W-1:0] fx_s;
    logic signed [F_W-1:0] fy_s;
    logic                  xz_s;
    logic                  yz_s;

    logic                  s1_valid_r;
    enc_t                  s1_x_r;
    enc_t                  s1_y_r;

    logic signed [L_W-1:0] kd_s;
    logic signed [L_W-1:0] l_s;

    logic                  s2_valid_r;
    logic signed [L_W-1:0] s2_l_r;
    logic                  s2_xz_r;
    logic                  s2_yz_r;

    logic [N_W-1:0]        n_s;
    logic [N_W-1:0]        neg_n_s;
    logic [M_W-1:0]        mant_s;
    logic [Q_W-1:0]        wide_s;
    logic [Q_W-1:0]        q_s;
    logic                  dz_s;

    // The whole pipeline moves together, so upstream readiness is just
    // "output slot free or being drained this cycle".
    assign advance_s = ~valid_o | ready_i;
    assign ready_o   = advance_s;
    assign accept_s  = valid_i & advance_s;

    nod_log_encode u_enc_x (
        .v    (x_i),
        .k    (kx_s),
        .f    (fx_s),
        .zero (xz_s)
    );

    nod_log_encode u_enc_y (
        .v    (y_i),
        .k    (ky_s),
        .f    (fy_s),
        .zero (yz_s)
    );

    // S1 register: encoded operands and stage valid
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_r <= 1'b0;
            s1_x_r     <= ENC_CLR;
            s1_y_r     <= ENC_CLR;
        end else if (advance_s) begin
            s1_valid_r <= accept_s;
            s1_x_r     <= '{zero: xz_s, k: kx_s, f: fx_s};
            s1_y_r     <= '{zero: yz_s, k: ky_s, f: fy_s};
        end
    end

    // S2 combinational: log difference in signed Q5.8
    always_comb begin
        kd_s = $signed({{(L_W-K_W){1'b0}}, s1_x_r.k})
             - $signed({{(L_W-K_W){1'b0}}, s1_y_r.k});
        l_s  = (kd_s <<< FRAC_W)
             + $signed({{(L_W-F_W){s1_x_r.f[F_W-1]}}, s1_x_r.f})
             - $signed({{(L_W-F_W){s1_y_r.f[F_W-1]}}, s1_y_r.f});
    end

    // S2 register: log difference plus the zero flags that override it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_r <= 1'b0;
            s2_l_r     <= {L_W{1'b0}};
            s2_xz_r    <= 1'b0;
            s2_yz_r    <= 1'b0;
        end else if (advance_s) begin
            s2_valid_r <= s1_valid_r;
            s2_l_r     <= l_s;
            s2_xz_r    <= s1_x_r.zero;
            s2_yz_r    <= s1_y_r.zero;
        end
    end

    // S3 combinational: antilog. The upper bits of L are n = floor(L/256)
    // in two's complement; the low byte is the mantissa fraction.
    always_comb begin
        n_s     = s2_l_r[L_W-1:FRAC_W];
        neg_n_s = -n_s;
        mant_s  = {1'b1, s2_l_r[FRAC_W-1:0]};
        wide_s  = {{(Q_W-M_W){1'b0}}, mant_s};
        q_s     = {Q_W{1'b0}};
        dz_s    = 1'b0;
        if (s2_yz_r) begin
            q_s  = Q_SAT;
            dz_s = 1'b1;
        end else if (s2_xz_r) begin
            q_s  = {Q_W{1'b0}};
        end else if (n_s[N_W-1]) begin
            // Negative exponent: right shift truncates toward zero
            q_s  = wide_s >> neg_n_s;
        end else if (n_s >= N_SAT) begin
            q_s  = Q_SAT;
        end else begin
            q_s  = wide_s << n_s;
        end
    end

    // S3 register: registered result outputs; data only updates on a real result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            q_o     <= {Q_W{1'b0}};
            dz_o    <= 1'b0;
        end else if (advance_s) begin
            valid_o <= s2_valid_r;
            if (s2_valid_r) begin
                q_o  <= q_s;
                dz_o <= dz_s;
            end
        end
    end

endmodule : nod_log_divider

// File: tb/tb_nod_log_divider.sv
// -----------------------------------------------------------------------------
// tb_nod_log_divider
// Self-checking bench for nod_log_divider. Inputs change on the falling edge,
// outputs are sampled 1 ns later, transfers happen on the following rising
// edge. Expected results come from an integer-arithmetic reference of the
// log-divide rules, kept in an in-order scoreboard queue.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nod_log_divider;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  x_i;
    logic [7:0]  y_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] q_o;
    logic        dz_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [16:0] exp_q[$];   // {dz, q}

    always #5 clk_i = ~clk_i;

    nod_log_divider #(.FRAC_W(8)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .x_i     (x_i),
        .y_i     (y_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .q_o     (q_o),
        .dz_o    (dz_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // log2 approximation of one operand: v ~= 2^k * (1 + f/256)
    function automatic void ref_enc(input int v, output int k, output int f);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (v >= (1 << i)) p = i;
        end
        k = p;
        if (p > 0 && 2 * v >= 3 * (1 << p)) k = p + 1;
        f = (v - (1 << k)) * (1 << (8 - k));
    endfunction

    function automatic logic [16:0] ref_div(input int x, input int y);
        int kx, fx, ky, fy, l, n, m, mant, q;
        logic [15:0] qv;
        if (y == 0) return {1'b1, 16'hFFFF};
        if (x == 0) return {1'b0, 16'h0000};
        ref_enc(x, kx, fx);
        ref_enc(y, ky, fy);
        l = (kx - ky) * 256 + fx - fy;
        if (l >= 0) n = l / 256;
        else        n = -((-l + 255) / 256);
        m    = l - n * 256;
        mant = 256 + m;
        if (n >= 8)      q = 65535;
        else if (n >= 0) q = mant * (1 << n);
        else             q = mant / (1 << (-n));
        qv = 16'(q);
        return {1'b0, qv};
    endfunction

    function automatic logic [7:0] rnd_op();
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) return 8'd0;
        if (sel == 1) return 8'd255;
        if (sel == 2) return 8'(1 << $urandom_range(0, 7));
        return 8'($urandom_range(0, 255));
    endfunction

    // Single operation into an empty pipeline: latency, constant and model check
    task automatic run_directed(input string tag, input logic [7:0] x, input logic [7:0] y,
                                input logic [15:0] eq, input logic edz);
        int lat;
        logic [16:0] e;
        @(negedge clk_i);
        ready_i = 1'b1;
        valid_i = 1'b1;
        x_i     = x;
        y_i     = y;
        #1;
        check_val({tag, "_rdy"}, 32'(ready_o), 32'd1);
        @(negedge clk_i);
        valid_i = 1'b0;
        lat     = 1;
        while (valid_o !== 1'b1 && lat < 8) begin
            @(negedge clk_i);
            lat++;
        end
        check_val({tag, "_lat"}, 32'(lat), 32'd3);
        check_val({tag, "_q"}, 32'(q_o), 32'(eq));
        check_val({tag, "_dz"}, 32'(dz_o), 32'(edz));
        e = ref_div(int'(x), int'(y));
        check_val({tag, "_model"}, 32'(q_o), 32'(e[15:0]));
    endtask

    // Call just after a falling edge: consume all expected results, bounded
    task automatic drain(input string tag, input int budget);
        int cyc;
        logic [16:0] e;
        cyc     = 0;
        ready_i = 1'b1;
        valid_i = 1'b0;
        while (exp_q.size() > 0 && cyc < budget) begin
            #1;
            if (valid_o === 1'b1) begin
                e = exp_q.pop_front();
                check_val({tag, "_q"}, 32'(q_o), 32'(e[15:0]));
                check_val({tag, "_dz"}, 32'(dz_o), 32'(e[16]));
            end
            cyc++;
            @(negedge clk_i);
        end
        check_val({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] e;
        logic [15:0] held_q;
        logic        held_dz;
        logic        hold_chk;

        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        x_i     = 8'd0;
        y_i     = 8'd0;
        repeat (3) @(negedge clk_i);
        #1;
        check_val("rst_valid", 32'(valid_o), 32'd0);
        check_val("rst_q", 32'(q_o), 32'd0);
        check_val("rst_dz", 32'(dz_o), 32'd0);
        check_val("rst_ready", 32'(ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        check_val("post_rst_valid", 32'(valid_o), 32'd0);

        // Directed corner cases
        run_directed("d64_8", 8'd64, 8'd8, 16'h0800, 1'b0);
        run_directed("d96_4", 8'd96, 8'd4, 16'h1C00, 1'b0);
        run_directed("d255_1", 8'd255, 8'd1, 16'hFF80, 1'b0);
        run_directed("d1_255", 8'd1, 8'd255, 16'h0001, 1'b0);
        run_directed("d0_5", 8'd0, 8'd5, 16'h0000, 1'b0);
        run_directed("dz0", 8'd0, 8'd0, 16'hFFFF, 1'b1);
        run_directed("dz77", 8'd77, 8'd0, 16'hFFFF, 1'b1);
        run_directed("dz255", 8'd255, 8'd0, 16'hFFFF, 1'b1);

        // Back-to-back into a stalled output
        @(negedge clk_i);
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            x_i     = 8'($urandom_range(1, 255));
            y_i     = 8'($urandom_range(1, 255));
            #1;
            check_val("stall_acc", 32'(ready_o), 32'd1);
            exp_q.push_back(ref_div(int'(x_i), int'(y_i)));
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        #1;
        check_val("stall_valid", 32'(valid_o), 32'd1);
        check_val("stall_ready", 32'(ready_o), 32'd0);
        held_q  = q_o;
        held_dz = dz_o;
        repeat (3) begin
            @(negedge clk_i);
            #1;
            check_val("stall_hold_q", 32'(q_o), 32'(held_q));
            check_val("stall_hold_dz", 32'(dz_o), 32'(held_dz));
            check_val("stall_hold_rdy", 32'(ready_o), 32'd0);
        end
        @(negedge clk_i);
        drain("stall_drain", 12);

        // Randomized traffic with random back-pressure
        hold_chk = 1'b0;
        held_q   = 16'h0000;
        held_dz  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_i);
            valid_i = ($urandom_range(0, 9) < 7);
            x_i     = rnd_op();
            y_i     = rnd_op();
            ready_i = ($urandom_range(0, 3) != 0);
            #1;
            if (hold_chk) begin
                check_val("rnd_hold_q", 32'(q_o), 32'(held_q));
                check_val("rnd_hold_dz", 32'(dz_o), 32'(held_dz));
            end
            if (valid_i && ready_o) begin
                exp_q.push_back(ref_div(int'(x_i), int'(y_i)));
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check_val("rnd_extra", 32'(valid_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("rnd_q", 32'(q_o), 32'(e[15:0]));
                    check_val("rnd_dz", 32'(dz_o), 32'(e[16]));
                end
            end
            hold_chk = valid_o && !ready_i;
            held_q   = q_o;
            held_dz  = dz_o;
        end
        @(negedge clk_i);
        drain("rnd_drain", 20);

        // Reset with operations in flight
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            x_i     = 8'($urandom_range(1, 255));
            y_i     = 8'($urandom_range(1, 255));
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        #1;
        check_val("inflight_valid", 32'(valid_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(valid_o), 32'd0);
        check_val("mid_rst_q", 32'(q_o), 32'd0);
        check_val("mid_rst_ready", 32'(ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            #1;
            check_val("no_stale", 32'(valid_o), 32'd0);
        end
        run_directed("after_rst", 8'd64, 8'd8, 16'h0800, 1'b0);

        @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_nod_log_divider
